cmp_sort_ctrl: RTL and testbench



---
 rtl/cmp_sort_pkg.sv | 13 +
 rtl/n_bit_comparator.sv | 16 +
 rtl/cmp_sort_ctrl.sv | 155 +++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sort_pkg.sv
// Shared definitions for the sequential block sorter: FSM encoding and default geometry.
package cmp_sort_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/n_bit_comparator.sv
// Unsigned magnitude comparator; exactly one of greater/lesser/equal is high.
module n_bit_comparator #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    assign greater = (a > b);
    assign lesser  = (a < b);
    assign equal   = (a == b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Buffers DEPTH words, bubble-sorts them ascending with one shared comparator
// (one compare per cycle), then streams the block out with out_last on the final word.
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PEN_PTR  = PW'(DEPTH - 2);

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            swap_seen_q, swap_seen_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    idx_nxt;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             greater, lesser, equal;
    logic             load_fire, swap_en;

    assign idx_nxt = idx_q + PW'(1);
    assign cmp_a   = mem[idx_q];
    assign cmp_b   = mem[idx_nxt];

    n_bit_comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a       (cmp_a),
        .b       (cmp_b),
        .greater (greater),
        .lesser  (lesser),
        .equal   (equal)
    );

    // flush suppresses any write in the same cycle
    assign load_fire = (state_q == LOAD) && in_valid && !flush;
    assign swap_en   = (state_q == SORT) && greater && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load_fire) begin
            mem[wr_ptr_q] <= in_data;
        end else if (swap_en) begin
            mem[idx_q]   <= cmp_b;
            mem[idx_nxt] <= cmp_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            idx_q       <= '0;
            rd_ptr_q    <= '0;
            swap_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            idx_q       <= idx_d;
            rd_ptr_q    <= rd_ptr_d;
            swap_seen_q <= swap_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        idx_d       = idx_q;
        rd_ptr_d    = rd_ptr_q;
        swap_seen_d = swap_seen_q;

        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d     = SORT;
                        wr_ptr_d    = '0;
                        idx_d       = '0;
                        swap_seen_d = 1'b0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
            end
            SORT: begin
                if (greater) begin
                    swap_seen_d = 1'b1;
                end
                // A swap on the final pair of the pass still demands another pass.
                if (idx_q == PEN_PTR) begin
                    idx_d       = '0;
                    swap_seen_d = 1'b0;
                    if (!(swap_seen_q || greater)) begin
                        state_d  = DRAIN;
                        rd_ptr_d = '0;
                    end
                end else begin
                    idx_d = idx_nxt;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        state_d  = LOAD;
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (flush) begin
            state_d     = LOAD;
            wr_ptr_d    = '0;
            idx_d       = '0;
            rd_ptr_d    = '0;
            swap_seen_d = 1'b0;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = (state_q == DRAIN) ? mem[rd_ptr_q] : '0;
    assign out_last  = (state_q == DRAIN) && (rd_ptr_q == LAST_PTR);
    assign busy      = (state_q == SORT) || (state_q == DRAIN);

    a_cmp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SORT) |-> $onehot({greater, lesser, equal}));

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl: a reference sort and pass-count model feed
// expectation queues; a negedge monitor pops and compares every transfer.
module tb_cmp_sort_ctrl;

    localparam int W = 16;
    localparam int D = 8;

    typedef logic [W-1:0] word_t;
    typedef word_t blk_t [D];

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [W-1:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [W-1:0] out_data;
    logic        out_last;
    logic        busy;

    cmp_sort_ctrl #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    word_t exp_q[$];
    bit    last_q[$];
    int    cyc_q[$];
    int    drained  = 0;
    bit    bp       = 1'b0;

    int    sort_cnt   = 0;
    bit    in_drain   = 1'b0;
    bit    prev_stall = 1'b0;
    word_t prev_data;
    logic  prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=missing required=present", name);
    endtask

    // Reference: stable ascending order; bubble passes = 1 + max count of larger
    // elements preceding any element (its leftward travel distance).
    task automatic push_block(input blk_t w);
        word_t s[$];
        int    maxinv;
        maxinv = 0;
        for (int i = 0; i < D; i++) begin
            int pos;
            int inv;
            pos = s.size();
            for (int j = 0; j < s.size(); j++) begin
                if (s[j] > w[i]) begin
                    pos = j;
                    break;
                end
            end
            s.insert(pos, w[i]);
            inv = 0;
            for (int j = 0; j < i; j++) begin
                if (w[j] > w[i]) inv++;
            end
            if (inv > maxinv) maxinv = inv;
        end
        for (int k = 0; k < D; k++) begin
            exp_q.push_back(s[k]);
            last_q.push_back(k == D - 1);
        end
        cyc_q.push_back((D - 1) * (maxinv + 1));
    endtask

    task automatic send_block(input blk_t w);
        push_block(w);
        for (int i = 0; i < D; i++) begin
            int stall;
            int guard;
            stall = $urandom_range(0, 2);
            in_valid = 1'b0;
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            guard    = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                guard++;
                if (guard > 3000) begin
                    $display("FAIL in_ready_timeout actual=0 required=1");
                    $fatal(1, "in_ready never asserted");
                end
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain_wait();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            last_q.delete();
            cyc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sort_cnt   = 0;
            in_drain   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_vs_busy", in_ready, !busy);
            if (busy && !out_valid) sort_cnt++;
            if (out_valid && !in_drain) begin
                in_drain = 1'b1;
                if (cyc_q.size() == 0) fail_now("sort_cycles_expectation");
                else chk("sort_cycles", sort_cnt, cyc_q.pop_front());
                sort_cnt = 0;
            end
            if (out_valid && prev_stall) begin
                chk("stall_data_stable", out_data, prev_data);
                chk("stall_last_stable", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("out_word_expectation");
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    chk("out_last", out_last, last_q.pop_front());
                end
                drained++;
                if (out_last) in_drain = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        blk_t b1, b_sorted, b_rev, b_dup, br;
        int   base;
        int   guard;

        b1       = '{16'd2, 16'd44, 16'd555, 16'd8888, 16'd4545, 16'd9999, 16'd888, 16'd444};
        b_sorted = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        b_rev    = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        b_dup    = '{16'd7, 16'd3, 16'd7, 16'd3, 16'd0, 16'd0, 16'd65535, 16'd7};

        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_block(b1);
        send_block(b_sorted);
        send_block(b_rev);
        send_block(b_dup);
        drain_wait();

        bp = 1'b1;
        send_block(b1);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < D; i++) begin
                br[i] = (r % 2 == 1) ? word_t'($urandom_range(0, 3)) : word_t'($urandom());
            end
            send_block(br);
        end
        drain_wait();
        bp = 1'b0;

        // Asynchronous reset in the middle of a long sort.
        send_block(b_rev);
        repeat (10) @(posedge clk);
        #2;
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        last_q.delete();
        cyc_q.delete();
        chk("midsort_rst_in_ready", in_ready, 1);
        chk("midsort_rst_out_valid", out_valid, 0);
        chk("midsort_rst_out_data", out_data, 0);
        chk("midsort_rst_out_last", out_last, 0);
        chk("midsort_rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_block(b1);
        drain_wait();

        // Flush right after the third drained word.
        base = drained;
        send_block(b_rev);
        guard = 0;
        while (drained < base + 3 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        chk("flush_reached_third_word", drained - base, 3);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        flush = 1'b0;
        exp_q.delete();
        last_q.delete();
        cyc_q.delete();
        send_block(b_dup);
        drain_wait();

        chk("final_in_ready", in_ready, 1);
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
